// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the SRAM controller state type and the byte-strobe decode.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_ERR1,
        ST_ERR2
    } ctrl_state_t;

    // Little-endian lane strobe; address bits below the transfer size are ignored.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] strobe;
        strobe = 4'b0000;
        case (size)
            HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
            HSIZE_HALF: strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strobe = 4'b1111;
            default:    strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous SRAM with per-byte write enables and a registered read port.
module sram_sp #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1 << AW) - 1];

    // Byte-lane writes; lanes without an enable keep their old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register only loads on a read, so it holds the last read word otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'h0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave front end for the on-chip SRAM: phase registers, hazard/error FSM, SRAM port mux.
module ahb_sram_ctrl
    import ahb_pkg::*;
#(
    parameter int MEM_AW = 14
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hburst,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    ctrl_state_t       state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;

    logic              xfer_valid;
    logic              accept;
    logic [MEM_AW-1:0] haddr_word;

    logic [3:0]        sram_we;
    logic              sram_re;
    logic [MEM_AW-1:0] sram_addr;

    logic              unused_bits;

    assign unused_bits = ^{hburst, haddr[31:MEM_AW+2]};

    assign haddr_word = haddr[MEM_AW+1:2];
    assign xfer_valid = hsel && hready_in && (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
    assign accept     = xfer_valid && (state_q != ST_RD_WAIT) && (state_q != ST_ERR1);

    // Phase registers; reset drops any data phase in flight so a pending write never lands.
    always_ff @(posedge hclk or posedge hrstn) begin
        if (hrstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
        end
    end

    // Next state and SRAM port: the write data phase owns the port, so a read arriving then is deferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        sram_we   = 4'b0000;
        sram_re   = 1'b0;
        sram_addr = addr_q;

        case (state_q)
            ST_WR:      sram_we = be_q;
            ST_RD_WAIT: sram_re = 1'b1;
            default:    ;
        endcase

        case (state_q)
            ST_RD_WAIT: state_d = ST_RD;
            ST_ERR1:    state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (hsize > HSIZE_WORD) begin
                        state_d = ST_ERR1;
                    end else begin
                        addr_d = haddr_word;
                        be_d   = byte_strobe(hsize, haddr[1:0]);
                        if (hwrite) begin
                            state_d = ST_WR;
                        end else if (state_q == ST_WR) begin
                            state_d = ST_RD_WAIT;
                        end else begin
                            state_d   = ST_RD;
                            sram_re   = 1'b1;
                            sram_addr = haddr_word;
                        end
                    end
                end
            end
        endcase
    end

    // Response outputs decode straight from the state, giving OKAY/ready in reset and idle.
    always_comb begin
        hready_out = !((state_q == ST_RD_WAIT) || (state_q == ST_ERR1));
        hresp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    sram_sp #(
        .AW (MEM_AW)
    ) u_sram (
        .clk   (hclk),
        .rst   (hrstn),
        .we    (sram_we),
        .re    (sram_re),
        .addr  (sram_addr),
        .wdata (hwdata),
        .rdata (hrdata)
    );

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl: per-cycle expected responses queued as stimulus is driven.
module tb_ahb_sram_ctrl;

    logic        hclk;
    logic        hrstn;
    logic        hsel;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    typedef struct {
        string       tag;
        logic        ready;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int];
    logic [31:0] last_rdata;
    int          checks;
    int          errors;

    ahb_sram_ctrl #(
        .MEM_AW (14)
    ) dut (
        .hclk       (hclk),
        .hrstn      (hrstn),
        .hsel       (hsel),
        .htrans     (htrans),
        .hburst     (hburst),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .hready_in  (hready_in),
        .hready_out (hready_out),
        .hresp      (hresp),
        .hrdata     (hrdata)
    );

    // Free-running bus clock.
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    function automatic int wordIndex(input logic [31:0] addr);
        return int'(addr[15:2]);
    endfunction

    // Reference memory update: lanes chosen from size and low address bits.
    task automatic modelWrite(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] word;
        logic [3:0]  lanes;
        int          idx;
        idx = wordIndex(addr);
        word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        if (size == 3'd0)      lanes = 4'b0001 << addr[1:0];
        else if (size == 3'd1) lanes = addr[1] ? 4'b1100 : 4'b0011;
        else                   lanes = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) word[8*b +: 8] = data[8*b +: 8];
        end
        model_mem[idx] = word;
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        int idx;
        idx = wordIndex(addr);
        return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic exp_ready, input logic [1:0] exp_resp,
                               input logic [31:0] exp_rdata);
        checks++;
        assert (hready_out === exp_ready) else begin
            errors++;
            $error("[TB] FAIL %s hready_out got %0b want %0b", tag, hready_out, exp_ready);
        end
        checks++;
        assert (hresp === exp_resp) else begin
            errors++;
            $error("[TB] FAIL %s hresp got %0b want %0b", tag, hresp, exp_resp);
        end
        checks++;
        assert (hrdata === exp_rdata) else begin
            errors++;
            $error("[TB] FAIL %s hrdata got %08h want %08h", tag, hrdata, exp_rdata);
        end
    endtask

    // Drive one address phase and queue the response expected in the cycle after the next edge.
    task automatic applyStimulus(input string tag, input logic sel, input logic [1:0] trans,
                                 input logic [2:0] size, input logic wr, input logic [31:0] addr,
                                 input logic rdy, input logic exp_ready, input logic [1:0] exp_resp,
                                 input logic [31:0] exp_rdata);
        exp_t e;
        hsel      = sel;
        htrans    = trans;
        hsize     = size;
        hwrite    = wr;
        haddr     = addr;
        hready_in = rdy;
        e.tag     = tag;
        e.ready   = exp_ready;
        e.resp    = exp_resp;
        e.rdata   = exp_rdata;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge hclk);
        #1;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty size got %0d want >0", exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, e.ready, e.resp, e.rdata);
        end
    endtask

    // Directed sequence following the AHB pipeline one cycle at a time.
    initial begin
        logic [31:0] a_hi;
        logic [31:0] rd;
        checks     = 0;
        errors     = 0;
        last_rdata = 32'h0;
        a_hi       = 32'h1000_9fff;
        hrstn      = 1'b1;
        hsel       = 1'b0;
        htrans     = 2'b00;
        hburst     = 3'b000;
        hsize      = 3'b010;
        hwrite     = 1'b0;
        haddr      = 32'h0;
        hwdata     = 32'h0;
        hready_in  = 1'b1;

        repeat (3) @(posedge hclk);
        #1;
        checkOutput("reset", 1'b1, 2'b00, 32'h0);
        hrstn = 1'b0;

        // Word write, then byte read straight behind it (one wait state).
        applyStimulus("wr_word", 1, 2'b10, 3'b010, 1, a_hi, 1, 1'b1, 2'b00, last_rdata);
        tick();
        hwdata = 32'h1234_5678;
        modelWrite(3'b010, a_hi, hwdata);
        applyStimulus("raw_wait", 1, 2'b10, 3'b000, 0, a_hi, 1, 1'b0, 2'b00, last_rdata);
        tick();
        hwdata = 32'h0;
        last_rdata = modelRead(a_hi);
        applyStimulus("raw_data", 0, 2'b00, 3'b010, 0, 32'h0, 0, 1'b1, 2'b00, last_rdata);
        tick();

        // Back-to-back halfword and word reads, zero wait.
        applyStimulus("rd_half", 1, 2'b10, 3'b001, 0, a_hi, 1, 1'b1, 2'b00, modelRead(a_hi));
        tick();
        applyStimulus("rd_word", 1, 2'b11, 3'b010, 0, a_hi, 1, 1'b1, 2'b00, modelRead(a_hi));
        tick();

        // Gated writes must not reach the SRAM.
        applyStimulus("gate_rdy", 1, 2'b10, 3'b010, 1, a_hi, 0, 1'b1, 2'b00, last_rdata);
        tick();
        hwdata = 32'hDEAD_BEEF;
        applyStimulus("gate_sel", 0, 2'b10, 3'b010, 1, a_hi, 1, 1'b1, 2'b00, last_rdata);
        tick();
        hwdata = 32'hCAFE_F00D;
        applyStimulus("gate_idle", 1, 2'b00, 3'b010, 1, a_hi, 1, 1'b1, 2'b00, last_rdata);
        tick();
        hwdata = 32'h0BAD_BAD0;
        applyStimulus("gate_busy", 1, 2'b01, 3'b010, 1, a_hi, 1, 1'b1, 2'b00, last_rdata);
        tick();
        hwdata = 32'h5555_AAAA;
        last_rdata = modelRead(a_hi);
        applyStimulus("gate_rd", 1, 2'b10, 3'b010, 0, a_hi, 1, 1'b1, 2'b00, last_rdata);
        tick();

        // Byte write to lane 1, then word read after write.
        applyStimulus("wr_byte", 1, 2'b10, 3'b000, 1, 32'h1000_9ffd, 1, 1'b1, 2'b00, last_rdata);
        tick();
        hwdata = 32'h0000_AB00;
        modelWrite(3'b000, 32'h1000_9ffd, hwdata);
        applyStimulus("bw_wait", 1, 2'b10, 3'b010, 0, a_hi, 1, 1'b0, 2'b00, last_rdata);
        tick();
        hwdata = 32'h0;
        last_rdata = modelRead(a_hi);
        applyStimulus("bw_data", 0, 2'b00, 3'b010, 0, 32'h0, 0, 1'b1, 2'b00, last_rdata);
        tick();

        // Back-to-back word and upper-halfword writes on word 0, then read after write.
        applyStimulus("wr_w0", 1, 2'b10, 3'b010, 1, 32'h0, 1, 1'b1, 2'b00, last_rdata);
        tick();
        hwdata = 32'h1122_3344;
        modelWrite(3'b010, 32'h0, hwdata);
        applyStimulus("wr_h0", 1, 2'b10, 3'b001, 1, 32'h2, 1, 1'b1, 2'b00, last_rdata);
        tick();
        hwdata = 32'hBEEF_0000;
        modelWrite(3'b001, 32'h2, hwdata);
        applyStimulus("h0_wait", 1, 2'b10, 3'b010, 0, 32'h0, 1, 1'b0, 2'b00, last_rdata);
        tick();
        hwdata = 32'h0;
        last_rdata = modelRead(32'h0);
        applyStimulus("h0_data", 0, 2'b00, 3'b010, 0, 32'h0, 0, 1'b1, 2'b00, last_rdata);
        tick();

        // Illegal sizes: two-cycle ERROR, no SRAM access.
        applyStimulus("err_rd1", 1, 2'b10, 3'b011, 0, a_hi, 1, 1'b0, 2'b01, last_rdata);
        tick();
        applyStimulus("err_rd2", 0, 2'b00, 3'b010, 0, 32'h0, 0, 1'b1, 2'b01, last_rdata);
        tick();
        applyStimulus("err_wr1", 1, 2'b10, 3'b100, 1, a_hi, 1, 1'b0, 2'b01, last_rdata);
        tick();
        hwdata = 32'hFFFF_FFFF;
        applyStimulus("err_wr2", 0, 2'b00, 3'b010, 0, 32'h0, 0, 1'b1, 2'b01, last_rdata);
        tick();
        hwdata = 32'h0;
        last_rdata = modelRead(a_hi);
        applyStimulus("post_err", 1, 2'b10, 3'b010, 0, a_hi, 1, 1'b1, 2'b00, last_rdata);
        tick();
        applyStimulus("hold", 0, 2'b00, 3'b010, 0, 32'h0, 1, 1'b1, 2'b00, last_rdata);
        tick();

        // Reset during a write data phase aborts the write.
        applyStimulus("rst_wr", 1, 2'b10, 3'b010, 1, 32'h1000_9ffc, 1, 1'b1, 2'b00, last_rdata);
        tick();
        hwdata = 32'hFFFF_FFFF;
        hsel   = 1'b0;
        htrans = 2'b00;
        #2;
        hrstn = 1'b1;
        #1;
        checkOutput("rst_mid", 1'b1, 2'b00, 32'h0);
        @(posedge hclk);
        #1;
        hrstn      = 1'b0;
        hwdata     = 32'h0;
        last_rdata = 32'h0;
        rd         = modelRead(a_hi);
        applyStimulus("rst_rd", 1, 2'b10, 3'b010, 0, a_hi, 1, 1'b1, 2'b00, rd);
        tick();
        applyStimulus("final_idle", 0, 2'b00, 3'b010, 0, 32'h0, 1, 1'b1, 2'b00, rd);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
